// File: rtl/data_bus_sizer_if.sv
// Core/memory data port bundle for data_bus_sizer: slave = the sizer, master = core plus memory side.
// The mem_rddata input is a 1-cycle registered read; core_ready is the only backpressure to the core.
interface data_bus_sizer_if #(
  parameter int MEM_ADDRW = 16,
  parameter int DATAW     = 64
);
  logic                   core_req;
  logic [1:0]             core_cmd;
  logic [MEM_ADDRW+2:0]   core_addr;
  logic [2:0]             core_size;
  logic [DATAW-1:0]       core_wrdata;
  logic                   core_ready;
  logic                   core_ack;
  logic [DATAW-1:0]       core_rddata;
  logic                   core_err;
  logic                   mem_req;
  logic [1:0]             mem_cmd;
  logic [MEM_ADDRW-1:0]   mem_addr;
  logic [DATAW-1:0]       mem_wrdata;
  logic [DATAW-1:0]       mem_rddata;

  modport slave (
    input  core_req, core_cmd, core_addr, core_size, core_wrdata, mem_rddata,
    output core_ready, core_ack, core_rddata, core_err,
    output mem_req, mem_cmd, mem_addr, mem_wrdata
  );

  modport master (
    output core_req, core_cmd, core_addr, core_size, core_wrdata, mem_rddata,
    input  core_ready, core_ack, core_rddata, core_err,
    input  mem_req, mem_cmd, mem_addr, mem_wrdata
  );
endinterface

// File: rtl/data_bus_sizer.sv
// Sizes B/H/W/D core accesses onto a 64-bit memory (RMW for sub-dword stores); ack after 1/2/3/4 cycles
// (no-op or error / dword store / load / sub-dword store); one request in flight, core_ready high only in IDLE; misalign trap: DATA_BUS_SIZER_MISALIGN_TRAP_EN.
module data_bus_sizer #(
  parameter int MEM_ADDRW = 16,
  parameter int DATAW     = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  data_bus_sizer_if.slave   bus
);

  localparam logic [1:0] CMD_WR = 2'd1;
  localparam logic [1:0] CMD_RD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    WR_ISSUE,
    DONE
  } state_t;

  state_t                 state;
  logic                   ready_q;
  logic                   ack_q;
  logic                   err_q;
  logic [DATAW-1:0]       rddata_q;
  logic                   mem_req_q;
  logic [1:0]             mem_cmd_q;
  logic [MEM_ADDRW-1:0]   mem_addr_q;
  logic [DATAW-1:0]       mem_wrdata_q;

  logic                   lat_load;
  logic [2:0]             lat_size;
  logic [2:0]             lat_off;
  logic [DATAW-1:0]       lat_wrdata;

  logic [2:0]             req_mask;
  logic [2:0]             req_off;
  logic                   req_misalign;
  logic                   req_cmd_ok;

  logic [DATAW-1:0]       rd_shift;
  logic [DATAW-1:0]       load_val;
  logic                   sx;
  logic [7:0]             lane_base;
  logic [7:0]             lane_en;
  logic [DATAW-1:0]       bit_mask;
  logic [DATAW-1:0]       wr_shift;
  logic [DATAW-1:0]       merged;

  assign bus.core_ready  = ready_q;
  assign bus.core_ack    = ack_q;
  assign bus.core_err    = err_q;
  assign bus.core_rddata = rddata_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_cmd     = mem_cmd_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wrdata  = mem_wrdata_q;

  always_comb begin
    req_mask = 3'd0;
    case (bus.core_size[1:0])
      2'd0:    req_mask = 3'd0;
      2'd1:    req_mask = 3'd1;
      2'd2:    req_mask = 3'd3;
      default: req_mask = 3'd7;
    endcase
  end

  assign req_cmd_ok = (bus.core_cmd == CMD_WR) || (bus.core_cmd == CMD_RD);

`ifdef DATA_BUS_SIZER_MISALIGN_TRAP_EN
  assign req_off      = bus.core_addr[2:0];
  assign req_misalign = req_cmd_ok && (|(bus.core_addr[2:0] & req_mask));
`else
  // Unaligned offsets snap down to the natural boundary of the access size.
  assign req_off      = bus.core_addr[2:0] & ~req_mask;
  assign req_misalign = 1'b0;
`endif

  // Load path: bring the addressed lanes down to bit 0, then size and extend.
  assign rd_shift = bus.mem_rddata >> {lat_off, 3'b000};
  assign sx       = ~lat_size[2];

  always_comb begin
    load_val = '0;
    case (lat_size[1:0])
      2'd0:    load_val = {{56{sx & rd_shift[7]}},  rd_shift[7:0]};
      2'd1:    load_val = {{48{sx & rd_shift[15]}}, rd_shift[15:0]};
      2'd2:    load_val = {{32{sx & rd_shift[31]}}, rd_shift[31:0]};
      default: load_val = rd_shift;
    endcase
  end

  // Store path: lane enables for the addressed bytes, merged over the old word.
  always_comb begin
    lane_base = 8'h00;
    case (lat_size[1:0])
      2'd0:    lane_base = 8'h01;
      2'd1:    lane_base = 8'h03;
      2'd2:    lane_base = 8'h0F;
      default: lane_base = 8'hFF;
    endcase
  end

  assign lane_en  = lane_base << lat_off;
  assign wr_shift = lat_wrdata << {lat_off, 3'b000};

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{lane_en[i]}};
    end
  end

  assign merged = (bus.mem_rddata & ~bit_mask) | (wr_shift & bit_mask);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      ready_q      <= 1'b1;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rddata_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_cmd_q    <= 2'd0;
      mem_addr_q   <= '0;
      mem_wrdata_q <= '0;
      lat_load     <= 1'b0;
      lat_size     <= 3'd0;
      lat_off      <= 3'd0;
      lat_wrdata   <= '0;
    end else begin
      ack_q     <= 1'b0;
      mem_req_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.core_req && ready_q) begin
            ready_q    <= 1'b0;
            lat_load   <= (bus.core_cmd == CMD_RD);
            lat_size   <= bus.core_size;
            lat_off    <= req_off;
            lat_wrdata <= bus.core_wrdata;
            mem_addr_q <= bus.core_addr[MEM_ADDRW+2:3];
            if (!req_cmd_ok || req_misalign) begin
              state <= DONE;
              ack_q <= 1'b1;
              err_q <= req_misalign;
            end else if (bus.core_cmd == CMD_WR && bus.core_size[1:0] == 2'd3) begin
              state        <= WR_ISSUE;
              mem_req_q    <= 1'b1;
              mem_cmd_q    <= CMD_WR;
              mem_wrdata_q <= bus.core_wrdata;
            end else begin
              state     <= RD_ISSUE;
              mem_req_q <= 1'b1;
              mem_cmd_q <= CMD_RD;
            end
          end
        end
        RD_ISSUE: begin
          state <= RD_CAPT;
        end
        RD_CAPT: begin
          if (lat_load) begin
            rddata_q <= load_val;
            state    <= DONE;
            ack_q    <= 1'b1;
          end else begin
            mem_wrdata_q <= merged;
            mem_req_q    <= 1'b1;
            mem_cmd_q    <= CMD_WR;
            state        <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          state <= DONE;
          ack_q <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          err_q   <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
